// File: rtl/dpram_be_clr.sv
// True dual-port RAM with per-byte write enables, 1/2-cycle registered reads and a post-reset clear engine.
// Optional collision detector/counter is compiled in with `define DPRAM_COLLISION_EN.
module dpram_be_clr #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 32,
    parameter int                BYTE_W         = 8,
    parameter int                READ_LATENCY   = 1,
    parameter int                RDW_MODE       = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     busy,
    input  logic                     wren_a,
    input  logic                     rden_a,
    input  logic [DATA_W/BYTE_W-1:0] byteena_a,
    input  logic [ADDR_W-1:0]        address_a,
    input  logic [DATA_W-1:0]        data_a,
    output logic [DATA_W-1:0]        q_a,
    output logic                     valid_a,
    input  logic                     wren_b,
    input  logic                     rden_b,
    input  logic [DATA_W/BYTE_W-1:0] byteena_b,
    input  logic [ADDR_W-1:0]        address_b,
    input  logic [DATA_W-1:0]        data_b,
    output logic [DATA_W-1:0]        q_b,
    output logic                     valid_b
`ifdef DPRAM_COLLISION_EN
    ,
    output logic                     collision,
    output logic [7:0]               collision_count
`endif
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              en;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]        wr_en, rd_en;
    logic [NB-1:0]     be   [2];
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wdat [2];
    logic [DATA_W-1:0] rd_dat [2];

    logic [1:0]        p1_vld_q;
    logic [DATA_W-1:0] p1_dat_q [2];
    logic [1:0]        vld_q;
    logic [DATA_W-1:0] q_q [2];

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET != 0) begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) state_d = ST_READY;
            end else begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy   = (state_q == ST_CLEAR);
    assign en     = reset_n && (state_q == ST_READY);
    assign clr_we = reset_n && (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);

    assign wr_en   = {en & wren_b, en & wren_a};
    assign rd_en   = {en & rden_b, en & rden_a};
    assign be[0]   = byteena_a;
    assign be[1]   = byteena_b;
    assign addr[0] = address_a;
    assign addr[1] = address_b;
    assign wdat[0] = data_a;
    assign wdat[1] = data_b;

    // Port B lanes are written first so port A overrides them on a same-address collision.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_en[1] && be[1][i])
                    mem[addr[1]][i*BYTE_W +: BYTE_W] <= wdat[1][i*BYTE_W +: BYTE_W];
            end
            for (int i = 0; i < NB; i++) begin
                if (wr_en[0] && be[0][i])
                    mem[addr[0]][i*BYTE_W +: BYTE_W] <= wdat[0][i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Only a port's own write is merged; the other port's write is never visible this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = mem[addr[p]];
            if (RDW_MODE != 0) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_en[p] && be[p][i])
                        rd_dat[p][i*BYTE_W +: BYTE_W] = wdat[p][i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            p1_vld_q <= '0;
            vld_q    <= '0;
            for (int p = 0; p < 2; p++) begin
                p1_dat_q[p] <= '0;
                q_q[p]      <= '0;
            end
        end else begin
            p1_vld_q <= rd_en;
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) p1_dat_q[p] <= rd_dat[p];
            end
            if (READ_LATENCY == 2) begin
                vld_q <= p1_vld_q;
                for (int p = 0; p < 2; p++) begin
                    if (p1_vld_q[p]) q_q[p] <= p1_dat_q[p];
                end
            end else begin
                vld_q <= rd_en;
                for (int p = 0; p < 2; p++) begin
                    if (rd_en[p]) q_q[p] <= rd_dat[p];
                end
            end
        end
    end

    assign q_a     = q_q[0];
    assign q_b     = q_q[1];
    assign valid_a = vld_q[0];
    assign valid_b = vld_q[1];

`ifdef DPRAM_COLLISION_EN
    logic [1:0] wr_any;
    logic       coll_evt;
    logic       coll_q;
    logic [7:0] coll_cnt_q;

    assign wr_any   = {wr_en[1] && (|be[1]), wr_en[0] && (|be[0])};
    assign coll_evt = (addr[0] == addr[1]) &&
                      ((wr_any[0] && wr_any[1]) || (wr_any[0] && rd_en[1]) || (rd_en[0] && wr_any[1]));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q <= coll_evt;
            if (coll_evt && (coll_cnt_q != 8'hFF)) coll_cnt_q <= coll_cnt_q + 8'd1;
        end
    end

    assign collision       = coll_q;
    assign collision_count = coll_cnt_q;
`endif

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (latency 1/old-data and latency 2/new-data) share one stimulus stream.
// A reference memory predicts every read; a negedge monitor pops and compares results with their arrival cycle.
module tb_dpram_be_clr;

    localparam logic [31:0] CV = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wren_a = 1'b0, rden_a = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
    logic [3:0]  byteena_a = '0, byteena_b = '0;
    logic [3:0]  address_a = '0, address_b = '0;
    logic [31:0] data_a = '0, data_b = '0;

    logic        busy0, busy1;
    logic [31:0] q_a0, q_b0, q_a1, q_b1;
    logic        valid_a0, valid_b0, valid_a1, valid_b1;
`ifdef DPRAM_COLLISION_EN
    logic        coll0, coll1;
    logic [7:0]  ccnt0, ccnt1;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        rst_s = 1'b0;
    bit          ready_m = 1'b0;
    logic [31:0] ref_mem [16];
    exp_t        exq [4][$];
    logic [31:0] last_q [4];
    logic [31:0] qv [4];
    logic        vv [4];
    exp_t        me;

    dpram_be_clr #(.ADDR_W(4), .DATA_W(32), .BYTE_W(8), .READ_LATENCY(1), .RDW_MODE(0),
                   .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) dut0 (
        .clock(clock), .reset_n(reset_n), .busy(busy0),
        .wren_a(wren_a), .rden_a(rden_a), .byteena_a(byteena_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a0), .valid_a(valid_a0),
        .wren_b(wren_b), .rden_b(rden_b), .byteena_b(byteena_b), .address_b(address_b),
        .data_b(data_b), .q_b(q_b0), .valid_b(valid_b0)
`ifdef DPRAM_COLLISION_EN
        , .collision(coll0), .collision_count(ccnt0)
`endif
    );

    dpram_be_clr #(.ADDR_W(4), .DATA_W(32), .BYTE_W(8), .READ_LATENCY(2), .RDW_MODE(1),
                   .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) dut1 (
        .clock(clock), .reset_n(reset_n), .busy(busy1),
        .wren_a(wren_a), .rden_a(rden_a), .byteena_a(byteena_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a1), .valid_a(valid_a1),
        .wren_b(wren_b), .rden_b(rden_b), .byteena_b(byteena_b), .address_b(address_b),
        .data_b(data_b), .q_b(q_b1), .valid_b(valid_b1)
`ifdef DPRAM_COLLISION_EN
        , .collision(coll1), .collision_count(ccnt1)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_s <= reset_n;
    end

    // Streams: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
    always @(negedge clock) begin
        qv = '{q_a0, q_b0, q_a1, q_b1};
        vv = '{valid_a0, valid_b0, valid_a1, valid_b1};
        for (int s = 0; s < 4; s++) begin
            if (!rst_s) begin
                vectors++;
                if (vv[s] !== 1'b0 || qv[s] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL reset_out s%0d: valid=%b q=%h, want valid=0 q=0", s, vv[s], qv[s]);
                end
                last_q[s] = 32'h0;
                exq[s].delete();
            end else if (vv[s] === 1'b1) begin
                vectors++;
                if (exq[s].size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid s%0d: q=%h at cycle %0d, want no valid", s, qv[s], cyc);
                end else begin
                    me = exq[s].pop_front();
                    if (qv[s] !== me.dat || cyc != me.cyc) begin
                        miscompares++;
                        $display("FAIL read_data s%0d: got %h at cycle %0d, want %h at cycle %0d",
                                 s, qv[s], cyc, me.dat, me.cyc);
                    end
                end
                last_q[s] = qv[s];
            end else begin
                vectors++;
                if (vv[s] !== 1'b0 || qv[s] !== last_q[s]) begin
                    miscompares++;
                    $display("FAIL q_hold s%0d: valid=%b q=%h, want valid=0 q=%h", s, vv[s], qv[s], last_q[s]);
                end
                if (exq[s].size() != 0 && exq[s][0].cyc <= cyc) begin
                    miscompares++;
                    me = exq[s].pop_front();
                    $display("FAIL missing_valid s%0d: no valid at cycle %0d, want %h", s, cyc, me.dat);
                end
            end
        end
    end

    task automatic drive(input bit wa, input bit ra, input logic [3:0] bea, input logic [3:0] aa,
                         input logic [31:0] da, input bit wb, input bit rb, input logic [3:0] beb,
                         input logic [3:0] ab, input logic [31:0] db);
        exp_t        e;
        logic [31:0] oa, ob, ma, mb;
        wren_a = wa; rden_a = ra; byteena_a = bea; address_a = aa; data_a = da;
        wren_b = wb; rden_b = rb; byteena_b = beb; address_b = ab; data_b = db;
        if (ready_m) begin
            oa = ref_mem[aa];
            ob = ref_mem[ab];
            ma = oa;
            mb = ob;
            for (int i = 0; i < 4; i++) begin
                if (wa && bea[i]) ma[i*8 +: 8] = da[i*8 +: 8];
                if (wb && beb[i]) mb[i*8 +: 8] = db[i*8 +: 8];
            end
            if (ra) begin
                e.dat = oa; e.cyc = cyc + 1; exq[0].push_back(e);
                e.dat = ma; e.cyc = cyc + 2; exq[2].push_back(e);
            end
            if (rb) begin
                e.dat = ob; e.cyc = cyc + 1; exq[1].push_back(e);
                e.dat = mb; e.cyc = cyc + 2; exq[3].push_back(e);
            end
            for (int i = 0; i < 4; i++)
                if (wb && beb[i]) ref_mem[ab][i*8 +: 8] = db[i*8 +: 8];
            for (int i = 0; i < 4; i++)
                if (wa && bea[i]) ref_mem[aa][i*8 +: 8] = da[i*8 +: 8];
        end
        @(posedge clock); #1;
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size()) != 0 && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        vectors++;
        if ((exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size()) != 0) begin
            miscompares++;
            $display("FAIL drain: %0d reads outstanding, want 0",
                     exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size());
            for (int s = 0; s < 4; s++) exq[s].delete();
        end
    endtask

    // Counts cycles of busy after reset release; optionally hammers both ports while busy.
    task automatic count_busy(input bit poke, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (busy0 !== 1'b1 && busy1 !== 1'b1) break;
            if (busy0 !== busy1) begin
                vectors++; miscompares++;
                $display("FAIL busy_match: dut0=%b dut1=%b, want equal", busy0, busy1);
            end
            n++;
            if (poke) begin
                wren_a = 1'b1; rden_a = 1'b1; byteena_a = 4'hF; address_a = 4'(k); data_a = 32'h0;
                wren_b = 1'b1; rden_b = 1'b1; byteena_b = 4'hF; address_b = 4'(15 - k); data_b = 32'h12345678;
            end
        end
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = CV;
        ready_m = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        int n;
        ready_m = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: busy0=%b busy1=%b, want 1/1", busy0, busy1);
        end
        reset_n = 1'b1;
        count_busy(1'b1, n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL clear_cycles: busy lasted %0d cycles, want 16", n);
        end
        vectors++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_busy: busy0=%b busy1=%b, want 0/0", busy0, busy1);
        end
    endtask

    task automatic test_clear();
        for (int a = 0; a < 16; a++)
            drive(1'b0, 1'b1, 4'h0, 4'(15 - a), 32'h0, 1'b0, 1'b1, 4'h0, 4'(a), 32'h0);
        wait_drain();
    endtask

    task automatic test_byte_en();
        drive(1'b1, 1'b0, 4'b1111, 4'd3, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        drive(1'b1, 1'b0, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        drive(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'b0000, 4'd3, 32'h0BADF00D);
        drive(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 3; a++)
            drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'hF, 4'(a), 32'hC0DE0000 + 32'(a));
        for (int a = 0; a < 3; a++)
            drive(1'b0, 1'b1, 4'h0, 4'(a), 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        wait_drain();
    endtask

    task automatic test_rdw();
        drive(1'b1, 1'b0, 4'hF, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        drive(1'b1, 1'b1, 4'hF, 4'd5, 32'h55, 1'b0, 1'b1, 4'h0, 4'd5, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b1, 4'b0110, 4'd6, 32'h99887766);
        wait_drain();
    endtask

    task automatic test_dual_write();
`ifdef DPRAM_COLLISION_EN
        logic [7:0] c0, c1;
        c0 = ccnt0;
        c1 = ccnt1;
`endif
        drive(1'b1, 1'b0, 4'b0011, 4'd7, 32'h01010101, 1'b1, 1'b0, 4'b1110, 4'd7, 32'hFFFFFFFF);
`ifdef DPRAM_COLLISION_EN
        @(negedge clock);
        vectors++;
        if (coll0 !== 1'b1 || coll1 !== 1'b1 || ccnt0 !== c0 + 8'd1 || ccnt1 !== c1 + 8'd1) begin
            miscompares++;
            $display("FAIL collision: coll=%b/%b count=%0d/%0d, want 1/1 %0d/%0d",
                     coll0, coll1, ccnt0, ccnt1, c0 + 8'd1, c1 + 8'd1);
        end
        @(negedge clock);
        vectors++;
        if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_pulse: coll=%b/%b, want 0/0", coll0, coll1);
        end
        @(posedge clock); #1;
`endif
        drive(1'b0, 1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 1'b1, 4'h0, 4'd7, 32'h0);
        wait_drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++)
            drive(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
                  1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom);
        wait_drain();
    endtask

    task automatic test_mid_clear();
        int n;
        ready_m = 1'b0;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wren_a = 1'b1; byteena_a = 4'hF; address_a = 4'(k + 8); data_a = 32'h0;
            @(posedge clock); #1;
            vectors++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
                miscompares++;
                $display("FAIL early_busy: busy0=%b busy1=%b at clear cycle %0d, want 1/1", busy0, busy1, k);
            end
        end
        wren_a = 1'b0;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        count_busy(1'b1, n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL restart_cycles: busy lasted %0d cycles, want 16", n);
        end
        test_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clear();
        test_byte_en();
        test_back_to_back();
        test_rdw();
        test_dual_write();
        test_random();
        test_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
